// File: rtl/gnn_pkg.sv
// gnn_pkg: shared sizing constants, FSM state type and a neighbour-count
// helper for the GNN aggregation datapath.
//   MAC_OUT_SIZE : width of each incoming MAC lane result
//   MAC_IN_SIZE  : width of each quantized output lane
//   MAX_NBR      : maximum neighbour vectors summed per node
//   SHIFT        : requantization right-shift
//   ACC_W        : accumulator width, wide enough that MAX_NBR beats never overflow
package gnn_pkg;

    localparam int unsigned MAC_OUT_SIZE = 13;
    localparam int unsigned MAC_IN_SIZE  = 5;
    localparam int unsigned MAX_NBR      = 8;
    localparam int unsigned SHIFT        = 3;
    localparam int unsigned ACC_W        = MAC_OUT_SIZE + $clog2(MAX_NBR);

    // Width of the neighbour count, matching the cfg_nbr port.
    localparam int unsigned NBR_W = 4;

    typedef enum logic {
        StIdle  = 1'b0,
        StAccum = 1'b1
    } state_e;

    // A zero count still means "one vector"; anything above the limit is clipped.
    function automatic logic [NBR_W-1:0] clamp_nbr(input logic [NBR_W-1:0] cfg,
                                                    input int unsigned      max_nbr);
        if (cfg == '0) begin
            return NBR_W'(1);
        end
        if (32'(cfg) > max_nbr) begin
            return NBR_W'(max_nbr);
        end
        return cfg;
    endfunction

endpackage

// File: rtl/relu_quant.sv
// relu_quant: combinational per-lane activation and requantization.
// Applies ReLU, an arithmetic (floor) right shift, then clips to the largest
// positive value representable in OUT_W signed bits.
//   sum_i : signed accumulated lane value (ACC_W bits)
//   y_o   : quantized lane output (OUT_W bits, signed, never negative)
//   sat_o : high when the positive clip was applied
module relu_quant #(
    parameter int unsigned ACC_W = gnn_pkg::ACC_W,
    parameter int unsigned OUT_W = gnn_pkg::MAC_IN_SIZE,
    parameter int unsigned SHIFT = gnn_pkg::SHIFT
) (
    input  logic signed [ACC_W-1:0] sum_i,
    output logic signed [OUT_W-1:0] y_o,
    output logic                    sat_o
);

    localparam logic signed [ACC_W-1:0] YMax = ACC_W'((1 << (OUT_W - 1)) - 1);

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = sum_i >>> SHIFT;
        y_o     = '0;
        sat_o   = 1'b0;
        if (sum_i[ACC_W-1]) begin
            // Negative sums are zeroed by ReLU; that is not a saturation event.
            y_o = '0;
        end else if (shifted > YMax) begin
            y_o   = YMax[OUT_W-1:0];
            sat_o = 1'b1;
        end else begin
            y_o = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/gnn_aggregate.sv
// gnn_aggregate: sums N neighbour feature vectors (four MAC lanes per beat)
// into one node result, then applies ReLU / shift / saturate per lane.
//   clk, rst          : clock and synchronous active-high reset
//   mac_ready         : a beat is valid on in0..in3
//   in0..in3          : signed MAC lane results
//   cfg_nbr           : neighbour count, sampled on the first beat of a node
//   y0..y3            : quantized node features, held until the next result
//   agg_ready         : one-cycle pulse when y0..y3 carry a new result
//   sat               : some lane clipped in the presented result
//   node_idx          : index of the presented node (wraps at 256)
//   busy              : a node is partially accumulated
module gnn_aggregate #(
    parameter int unsigned MAC_OUT_SIZE = gnn_pkg::MAC_OUT_SIZE,
    parameter int unsigned MAC_IN_SIZE  = gnn_pkg::MAC_IN_SIZE,
    parameter int unsigned MAX_NBR      = gnn_pkg::MAX_NBR,
    parameter int unsigned SHIFT        = gnn_pkg::SHIFT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           mac_ready,
    input  logic signed [MAC_OUT_SIZE-1:0] in0,
    input  logic signed [MAC_OUT_SIZE-1:0] in1,
    input  logic signed [MAC_OUT_SIZE-1:0] in2,
    input  logic signed [MAC_OUT_SIZE-1:0] in3,
    input  logic [3:0]                     cfg_nbr,
    output logic signed [MAC_IN_SIZE-1:0]  y0,
    output logic signed [MAC_IN_SIZE-1:0]  y1,
    output logic signed [MAC_IN_SIZE-1:0]  y2,
    output logic signed [MAC_IN_SIZE-1:0]  y3,
    output logic                           agg_ready,
    output logic                           sat,
    output logic [7:0]                     node_idx,
    output logic                           busy
);

    import gnn_pkg::*;

    localparam int unsigned AccW  = MAC_OUT_SIZE + $clog2(MAX_NBR);
    localparam int unsigned Lanes = 4;

    logic signed [MAC_OUT_SIZE-1:0] lane_in [Lanes];

    state_e                  state_q;
    logic [NBR_W-1:0]        nbr_q;
    logic [NBR_W-1:0]        cnt_q;
    logic signed [AccW-1:0]  acc_q [Lanes];
    logic signed [MAC_IN_SIZE-1:0] y_q [Lanes];
    logic                    sat_q;
    logic                    agg_ready_q;
    logic [7:0]              node_idx_q;
    logic [7:0]              node_cnt_q;

    logic [NBR_W-1:0]              nbr_cur;
    logic [NBR_W-1:0]              cnt_next;
    logic                          final_beat;
    logic signed [AccW-1:0]        sum_d [Lanes];
    logic signed [MAC_IN_SIZE-1:0] q_lane [Lanes];
    logic [Lanes-1:0]              sat_lane;

    assign lane_in[0] = in0;
    assign lane_in[1] = in1;
    assign lane_in[2] = in2;
    assign lane_in[3] = in3;

    always_comb begin
        // In IDLE the count comes straight from cfg_nbr so N=1 finishes on its first beat.
        nbr_cur    = (state_q == StIdle) ? clamp_nbr(cfg_nbr, MAX_NBR) : nbr_q;
        cnt_next   = cnt_q + NBR_W'(1);
        final_beat = mac_ready && (cnt_next == nbr_cur);
        for (int i = 0; i < Lanes; i++) begin
            // Signed size cast sign-extends the lane into the accumulator width.
            sum_d[i] = (state_q == StIdle) ? AccW'(lane_in[i]) : acc_q[i] + AccW'(lane_in[i]);
        end
    end

    // Quantizers see the running sum so the final beat's result is ready to register.
    for (genvar g = 0; g < Lanes; g++) begin : g_lane
        relu_quant #(
            .ACC_W (AccW),
            .OUT_W (MAC_IN_SIZE),
            .SHIFT (SHIFT)
        ) u_relu_quant (
            .sum_i (sum_d[g]),
            .y_o   (q_lane[g]),
            .sat_o (sat_lane[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            nbr_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            agg_ready_q <= 1'b0;
            node_idx_q  <= '0;
            node_cnt_q  <= '0;
            for (int i = 0; i < Lanes; i++) begin
                acc_q[i] <= '0;
                y_q[i]   <= '0;
            end
        end else begin
            agg_ready_q <= 1'b0;
            if (mac_ready) begin
                nbr_q <= nbr_cur;
                for (int i = 0; i < Lanes; i++) begin
                    acc_q[i] <= sum_d[i];
                end
                if (final_beat) begin
                    // Back to IDLE so a beat next cycle opens a new node without a bubble.
                    state_q     <= StIdle;
                    cnt_q       <= '0;
                    sat_q       <= |sat_lane;
                    agg_ready_q <= 1'b1;
                    node_idx_q  <= node_cnt_q;
                    node_cnt_q  <= node_cnt_q + 8'd1;
                    for (int i = 0; i < Lanes; i++) begin
                        y_q[i] <= q_lane[i];
                    end
                end else begin
                    state_q <= StAccum;
                    cnt_q   <= cnt_next;
                end
            end
        end
    end

    assign y0        = y_q[0];
    assign y1        = y_q[1];
    assign y2        = y_q[2];
    assign y3        = y_q[3];
    assign sat       = sat_q;
    assign agg_ready = agg_ready_q;
    assign node_idx  = node_idx_q;
    assign busy      = (state_q == StAccum);

endmodule

// File: tb/tb_gnn_aggregate.sv
// Bench for gnn_aggregate: directed scenarios plus randomized beats, every
// cycle compared against an arithmetic node model (sum of beats, ReLU,
// floor divide by 2^SHIFT, clip to 15).
module tb_gnn_aggregate;

    localparam int MO      = 13;
    localparam int MI      = 5;
    localparam int MAXN    = 8;
    localparam int DIV     = 8;   // 2^SHIFT
    localparam int YMAX    = 15;  // 2^(MI-1)-1

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 mac_ready;
    logic signed [MO-1:0] in0, in1, in2, in3;
    logic [3:0]           cfg_nbr;
    logic signed [MI-1:0] y0, y1, y2, y3;
    logic                 agg_ready;
    logic                 sat;
    logic [7:0]           node_idx;
    logic                 busy;

    always #5 clk = ~clk;

    gnn_aggregate dut (
        .clk       (clk),
        .rst       (rst),
        .mac_ready (mac_ready),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .cfg_nbr   (cfg_nbr),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .agg_ready (agg_ready),
        .sat       (sat),
        .node_idx  (node_idx),
        .busy      (busy)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: beats collected for the current node, last presented result.
    int m_cnt  = 0;
    int m_n    = 1;
    int m_done = 0;
    int m_sum [4];
    int m_y   [4];
    bit m_sat = 1'b0;
    bit m_agg = 1'b0;
    int m_idx = 0;

    function automatic int ref_q(input int s);
        if (s <= 0) return 0;
        if (s / DIV > YMAX) return YMAX;
        return s / DIV;
    endfunction

    function automatic int rnd_in();
        if ($urandom_range(1) == 0) return int'($urandom_range(400)) - 200;
        return int'($urandom_range(8191)) - 4096;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input bit r, input bit v, input int a0, input int a1,
                        input int a2, input int a3, input int cfg);
        int ins [4];
        @(negedge clk);
        rst       = r;
        mac_ready = v;
        in0       = a0[MO-1:0];
        in1       = a1[MO-1:0];
        in2       = a2[MO-1:0];
        in3       = a3[MO-1:0];
        cfg_nbr   = cfg[3:0];
        @(posedge clk);
        ins[0] = a0; ins[1] = a1; ins[2] = a2; ins[3] = a3;
        if (r) begin
            m_cnt = 0; m_agg = 0; m_sat = 0; m_idx = 0; m_done = 0;
            for (int i = 0; i < 4; i++) begin
                m_y[i] = 0; m_sum[i] = 0;
            end
        end else begin
            m_agg = 0;
            if (v) begin
                if (m_cnt == 0) begin
                    m_n = (cfg == 0) ? 1 : (cfg > MAXN) ? MAXN : cfg;
                    for (int i = 0; i < 4; i++) m_sum[i] = 0;
                end
                for (int i = 0; i < 4; i++) m_sum[i] += ins[i];
                m_cnt++;
                if (m_cnt == m_n) begin
                    m_agg = 1;
                    m_sat = 0;
                    for (int i = 0; i < 4; i++) begin
                        m_y[i] = ref_q(m_sum[i]);
                        if (m_sum[i] > 0 && m_sum[i] / DIV > YMAX) m_sat = 1;
                    end
                    m_idx = m_done % 256;
                    m_done++;
                    m_cnt = 0;
                end
            end
        end
        #1;
        chk("agg_ready", agg_ready, m_agg);
        chk("busy", busy, m_cnt != 0);
        chk("y0", y0, m_y[0]);
        chk("y1", y1, m_y[1]);
        chk("y2", y2, m_y[2]);
        chk("y3", y3, m_y[3]);
        chk("sat", sat, m_sat);
        chk("node_idx", node_idx, m_idx);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; mac_ready = 1'b0; cfg_nbr = '0;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;

        // Reset state.
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle();

        // Single-beat node.
        step(0, 1, 8, -8, 100, 0, 1);
        chk("n1_agg", agg_ready, 1);
        chk("n1_y0", y0, 1);
        chk("n1_y1", y1, 0);
        chk("n1_y2", y2, 12);
        chk("n1_y3", y3, 0);
        chk("n1_sat", sat, 0);
        chk("n1_idx", node_idx, 0);
        idle();

        // Four beats with gaps; cfg_nbr changes mid-node are ignored.
        step(0, 1, 10, 0, 0, 0, 4);
        idle();
        step(0, 1, 10, 0, 0, 0, 0);
        idle();
        idle();
        step(0, 1, 10, 0, 0, 0, 15);
        chk("n4_early", agg_ready, 0);
        idle();
        step(0, 1, 10, 0, 0, 0, 1);
        chk("n4_agg", agg_ready, 1);
        chk("n4_y0", y0, 5);
        chk("n4_idx", node_idx, 1);
        idle();

        // Saturation and negative clamp.
        step(0, 1, 4095, -4096, 0, 0, 2);
        step(0, 1, 4095, -4096, 0, 0, 2);
        chk("sat_y0", y0, 15);
        chk("sat_y1", y1, 0);
        chk("sat_flag", sat, 1);

        // Back-to-back two-beat nodes.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 30, 1, 2, 3, 2);
        step(0, 1, 30, 1, 2, 3, 2);
        chk("b2b_agg0", agg_ready, 1);
        chk("b2b_idx0", node_idx, 0);
        step(0, 1, 5, 5, 5, 5, 2);
        chk("b2b_mid", agg_ready, 0);
        step(0, 1, 5, 5, 5, 5, 2);
        chk("b2b_agg1", agg_ready, 1);
        chk("b2b_idx1", node_idx, 1);

        // Mid-node reset (coincident with a beat), then a fresh 3-beat node.
        step(0, 1, 999, 999, 999, 999, 3);
        step(1, 1, 50, 50, 50, 50, 3);
        chk("rst_busy", busy, 0);
        chk("rst_y0", y0, 0);
        chk("rst_idx", node_idx, 0);
        step(0, 1, 20, -20, 40, 1, 3);
        step(0, 1, 20, -20, 40, 1, 3);
        step(0, 1, 20, -20, 40, 1, 3);
        chk("fresh_agg", agg_ready, 1);
        chk("fresh_y0", y0, 7);
        chk("fresh_y2", y2, 15);
        chk("fresh_sat", sat, 0);

        // cfg_nbr 0 acts as 1, 12 acts as 8.
        step(0, 1, 64, 0, 0, 0, 0);
        chk("cfg0_agg", agg_ready, 1);
        for (int k = 0; k < 7; k++) step(0, 1, 3, 3, 3, 3, 12);
        chk("cfg12_wait", agg_ready, 0);
        chk("cfg12_busy", busy, 1);
        step(0, 1, 3, 3, 3, 3, 12);
        chk("cfg12_agg", agg_ready, 1);
        chk("cfg12_y0", y0, 3);

        // node_idx wraps after 256 nodes.
        step(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 256; k++) step(0, 1, rnd_in(), rnd_in(), rnd_in(), rnd_in(), 1);
        chk("wrap_255", node_idx, 255);
        step(0, 1, rnd_in(), rnd_in(), rnd_in(), rnd_in(), 1);
        chk("wrap_0", node_idx, 0);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(63) == 0, $urandom_range(3) != 0, rnd_in(), rnd_in(),
                 rnd_in(), rnd_in(), int'($urandom_range(15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gnn_aggregate.md
GNN_AGGREGATE -- requirements
Module: gnn_aggregate

Interface
REQ-001 SHALL have parameter MAC_OUT_SIZE, default 13: width of each incoming MAC lane.
REQ-002 SHALL have parameter MAC_IN_SIZE, default 5: width of each output lane, which feeds the next layer's MAC x inputs.
REQ-003 SHALL have parameter MAX_NBR, default 8: maximum number of neighbour vectors per node.
REQ-004 SHALL have parameter SHIFT, default 3: requantization right-shift amount.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port mac_ready, input, 1 bit: a beat is valid on in0..in3 this cycle.
REQ-008 SHALL have ports in0, in1, in2, in3, input, signed MAC_OUT_SIZE each: MAC lane results.
REQ-009 SHALL have port cfg_nbr, input, 4 bits: neighbour count N for the node that is starting.
REQ-010 SHALL have ports y0, y1, y2, y3, output, signed MAC_IN_SIZE each: aggregated, activated and quantized node features.
REQ-011 SHALL have port agg_ready, output, 1 bit: pulses for one cycle when y0..y3 hold a new node result.
REQ-012 SHALL have port sat, output, 1 bit: at least one lane saturated for the node being presented.
REQ-013 SHALL have port node_idx, output, 8 bits: index of the node being presented.
REQ-014 SHALL have port busy, output, 1 bit: a node is partially accumulated.

Function
REQ-015 SHALL implement FSM states IDLE and ACCUM.
REQ-016 SHALL, on a beat in IDLE, latch N from cfg_nbr; cfg_nbr=0 is treated as 1 and values above MAX_NBR are clamped to MAX_NBR.
REQ-017 SHALL, on the first beat of a node, load each accumulator with its sign-extended lane value.
REQ-018 SHALL, on each later beat of a node, add the sign-extended lane value to its accumulator.
REQ-019 SHALL size each accumulator at MAC_OUT_SIZE+clog2(MAX_NBR) bits (16 at defaults); no internal overflow is possible.
REQ-020 SHALL hold accumulators and beat count unchanged in any cycle with mac_ready=0.
REQ-021 SHALL treat the beat that makes count equal N as final, and on the following cycle SHALL assert agg_ready for exactly one cycle with y updated.
REQ-022 SHALL compute each lane as: ReLU(acc+in) arithmetic-shifted right by SHIFT (floor), then saturated to 2^(MAC_IN_SIZE-1)-1 (15 at defaults).
REQ-023 SHALL update sat together with y, set to 1 if any lane clipped at REQ-022.
REQ-024 SHALL leave the FSM in IDLE after the final beat, so a beat on the next cycle starts a new node with no bubble; back-to-back nodes are allowed.
REQ-025 SHALL present node_idx with each result, then increment it after agg_ready, wrapping 255 to 0.
REQ-026 SHALL hold y, sat and node_idx stable between agg_ready pulses.
REQ-027 SHALL sample cfg_nbr only on the first beat of a node; changes during ACCUM are ignored.
REQ-028 SHALL, when N=1, treat the first beat as the final beat; the state remains IDLE.
REQ-029 SHALL drive busy=1 exactly when the state is ACCUM.

Reset
REQ-030 SHALL, while rst=1 at a clock edge, clear state to IDLE and set accumulators, beat count, y0..y3, sat, agg_ready, node_idx and busy to 0.
REQ-031 SHALL discard any partial node on a mid-node reset; rst takes priority over a simultaneous mac_ready.

Structure
REQ-032 SHALL place MAC_IN_SIZE, MAC_OUT_SIZE, MAX_NBR, the derived accumulator width and the FSM state enum in shared package gnn_pkg.
REQ-033 SHALL implement the per-lane ReLU/shift/saturate as combinational sub-module relu_quant, instantiated four times.

Verification
REQ-034 SHALL cover: N=1, in=(8,-8,100,0) -> one cycle later agg_ready=1, y=(1,0,12,0), sat=0, node_idx=0.
REQ-035 SHALL cover: N=4, in0=10 on four beats with idle cycles between them -> one agg_ready, one cycle after the 4th beat, y0=5, none earlier.
REQ-036 SHALL cover: N=2, in0=4095 on two beats -> y0=15, sat=1; in1=-4096 on the same beats -> y1=0.
REQ-037 SHALL cover: N=2 with 4 consecutive beats -> agg_ready one cycle after beats 2 and 4, node_idx 0 then 1.
REQ-038 SHALL cover: N=3, rst after 1 beat -> all outputs 0; the next 3 beats form a fresh node whose y reflects only those beats.
REQ-039 SHALL cover: cfg_nbr=0 and cfg_nbr=12 -> behave as N=1 and N=8; 256 nodes -> node_idx wraps to 0.
